add_accum: RTL
==============

Name: add_accum

Overview:
- Downstream consumer of the 32-bit adder blackbox's result/valid pair (c / c_vld).
- Sums a software-programmed number of valid adder results into a wide accumulator.
- Presents each block sum on a valid/ready output register.
- The upstream adder has no backpressure, so a result that cannot be buffered is dropped and counted, never stalled.

Parameters:
- DATA_W, 32, width of incoming samples (matches adder output).
- ACC_W, 40, accumulator/output width; must be >= DATA_W.
- LEN_W, 16, width of the block-length input and internal sample counter.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- ap_ce  in  1  clock enable for accumulation path (same meaning as upstream adder's ap_ce).
- start  in  1  one-cycle pulse; latches len and arms a block.
- len  in  LEN_W  number of samples per block; sampled on start.
- in_data  in  DATA_W  sample from adder (c).
- in_vld  in  1  sample valid from adder (c_vld).
- out_data  out  ACC_W  block sum.
- out_ovf  out  1  block sum wrapped ACC_W (carry lost) during that block.
- out_vld  out  1  out_data/out_ovf valid.
- out_rdy  in  1  consumer accepts when out_vld & out_rdy.
- busy  out  1  high in ACC state.
- drop_cnt  out  8  saturating count of block results lost because the output register was full.
- len_err  out  1  sticky; set by start with len==0.

Behaviour:
- Reset (ap_rst_n==0 at clock edge): state IDLE, acc=0, cnt=0, out_data=0, out_ovf=0, out_vld=0, busy=0, drop_cnt=0, len_err=0. Reset mid-block discards the partial sum and any pending output.
- FSM states: IDLE, ACC.
- IDLE:
  - start & len!=0 -> ACC; latch len into len_q; acc=0, cnt=0, ovf_q=0.
  - start & len==0 -> stay IDLE; len_err<=1.
  - in_vld is ignored in IDLE, including the start cycle itself; the first counted sample is the cycle after start.
- ACC:
  - A sample is taken when in_vld & ap_ce.
  - ap_ce=0 freezes acc/cnt/state; in_vld in that cycle is ignored, matching the adder's gating.
  - On a taken sample: sum = acc + zero-extended in_data, computed in ACC_W+1 bits. acc<=sum[ACC_W-1:0]. ovf_q |= sum[ACC_W]. cnt<=cnt+1.
  - Last sample is a taken sample with cnt==len_q-1. The final sum (including that sample's carry into out_ovf) goes to the output stage and the FSM returns to IDLE. Back-to-back blocks need a fresh start.
  - start while in ACC is ignored; len is not re-latched.
- Output stage:
  - Single register. Result appears on out_data/out_vld the cycle after the last sample (latency 1 from final in_vld).
  - out_vld holds, with out_data/out_ovf stable, until out_vld & out_rdy.
  - Accept and a new result in the same cycle: the new result loads, out_vld stays 1, no drop.
  - New result while out_vld=1 & !out_rdy: the new result is discarded, existing output unchanged, drop_cnt increments (saturates at 255).
  - out_rdy is not gated by ap_ce.
- busy = (state==ACC).
- len_err and drop_cnt clear only on reset.
- Arithmetic: unsigned, modulo 2^ACC_W. out_ovf flags the wrap.

Test Plan:
- Reset then start len=4, samples 1,2,3,4 on consecutive cycles, out_rdy=1 -> out_data=10, out_ovf=0, out_vld high exactly one cycle, one cycle after the sample 4 cycle; busy falls the same edge.
- len=3, samples 5,(ap_ce=0 with in_vld=1, data 100),6,7 -> out_data=18; the frozen cycle is not counted.
- ACC_W=40, len=300, all samples 0xFFFFFFFF -> out_data=(300*(2^32-1)) mod 2^40, out_ovf=1.
- Hold out_rdy=0, run two len=2 blocks (1+1, 2+2) -> out_data stays 2, drop_cnt=1; assert out_rdy -> accepted, out_vld drops. Repeat 300 times -> drop_cnt=255.
- start with len=0 -> busy stays 0, len_err=1, no output. start in IDLE with in_vld=1, data 9, then len=1 sample 3 -> out_data=3.
- Block in progress (2 of 5 samples), assert ap_rst_n=0 one cycle -> all outputs zero. New start len=1, sample 7 -> out_data=7.

Source files
------------

// File: rtl/add_accum.sv
// Sums a programmed number of adder results into a wide accumulator and holds each block sum for a valid/ready consumer.
// Result appears one cycle after the last sample; the adder cannot stall, so a result arriving at a full output is dropped and counted.
module add_accum #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_ce,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              busy,
  output logic [7:0]        drop_cnt,
  output logic              len_err
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_vld_q, out_vld_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic               len_err_q, len_err_d;

  logic [ACC_W:0]     sum;
  logic               res_vld;
  logic [ACC_W-1:0]   res_data;
  logic               res_ovf;

  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    len_err_d  = len_err_q;
    res_vld    = 1'b0;
    res_data   = sum[ACC_W-1:0];
    res_ovf    = ovf_q | sum[ACC_W];

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = ACC;
            len_d   = len;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      ACC: begin
        if (ap_ce && in_vld) begin
          acc_d = sum[ACC_W-1:0];
          ovf_d = ovf_q | sum[ACC_W];
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            res_vld = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: an accept in the same cycle frees the slot for the new result.
  always_comb begin
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    out_vld_d  = out_vld_q;
    drop_cnt_d = drop_cnt_q;

    if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end
    if (res_vld) begin
      if (!out_vld_q || out_rdy) begin
        out_data_d = res_data;
        out_ovf_d  = res_ovf;
        out_vld_d  = 1'b1;
      end else if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      drop_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      out_vld_q  <= out_vld_d;
      drop_cnt_q <= drop_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

  assign out_data = out_data_q;
  assign out_ovf  = out_ovf_q;
  assign out_vld  = out_vld_q;
  assign busy     = (state_q == ACC);
  assign drop_cnt = drop_cnt_q;
  assign len_err  = len_err_q;

endmodule
